// File: rtl/int_mult_pipe.sv
// Five-stage unsigned K x K multiplier built from 3x3 LIMB-wide partial products.
// Optional INT_MULT_PERF_CNT_EN adds an op_count/clr_count completed-product counter.

module int_mult_pipe_pp #(
  parameter int LIMB = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LIMB-1:0]     a_i,
  input  logic [LIMB-1:0]     b_i,
  output logic [2*LIMB-1:0]   p_o
);
  logic [2*LIMB-1:0] p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= (2*LIMB)'(a_i) * (2*LIMB)'(b_i);
  end

  assign p_o = p_q;
endmodule

module int_mult_pipe #(
  parameter int K    = 54,
  parameter int LIMB = 18,
  parameter int W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [K-1:0]     mult_a,
  input  logic [K-1:0]     mult_b,
  output logic             out_valid,
  output logic [2*K-1:0]   int_mult_result,
  output logic [W-1:0]     int_mult_result_low
`ifdef INT_MULT_PERF_CNT_EN
  ,
  input  logic             clr_count,
  output logic [31:0]      op_count
`endif
);
  localparam int STAGES = 5;
  localparam int PW     = 2*LIMB;
  localparam int CW     = 2*LIMB+2;
  localparam int RW     = 2*K;
  localparam int NCOL   = 5;

  logic [STAGES:1] vld_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
  end

  // S1: operand registers, viewed as three limbs with limb 0 in the LSBs
  logic [K-1:0] a_q, b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= mult_a;
      b_q <= mult_b;
    end
  end

  logic [2:0][LIMB-1:0] a_limb, b_limb;
  assign a_limb = a_q;
  assign b_limb = b_q;

  // S2: nine registered limb products, one DSP-sized multiplier each
  logic [2:0][2:0][PW-1:0] pp;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      int_mult_pipe_pp #(.LIMB(LIMB)) u_pp (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (a_limb[gi]),
        .b_i   (b_limb[gj]),
        .p_o   (pp[gi][gj])
      );
    end
  end

  // S3: column sums; two guard bits cover the three-term middle column
  logic [NCOL-1:0][CW-1:0] col_d, col_q;

  always_comb begin
    col_d = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        col_d[i+j] = col_d[i+j] + CW'(pp[i][j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) col_q <= '0;
    else        col_q <= col_d;
  end

  // S4: weighted accumulation split into low and high halves
  logic [RW-1:0] lo_d, hi_d, lo_q, hi_q;

  always_comb begin
    lo_d = RW'(col_q[0])
         + (RW'(col_q[1]) << LIMB)
         + (RW'(col_q[2]) << (2*LIMB));
    hi_d = (RW'(col_q[3]) << (3*LIMB))
         + (RW'(col_q[4]) << (4*LIMB));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  // S5: final add; the low slice gets its own copy for the reduction fanout
  logic [RW-1:0] sum_d, res_q;
  logic [W-1:0]  low_q;

  assign sum_d = lo_q + hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      low_q <= '0;
    end else begin
      res_q <= sum_d;
      low_q <= sum_d[W-1:0];
    end
  end

  assign out_valid           = vld_pipe_q[STAGES];
  assign int_mult_result     = res_q;
  assign int_mult_result_low = low_q;

`ifdef INT_MULT_PERF_CNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_count_q <= '0;
    else if (clr_count)          op_count_q <= '0;
    else if (vld_pipe_q[STAGES]) op_count_q <= op_count_q + 32'd1;
  end

  assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_int_mult_pipe.sv
// Bench for int_mult_pipe: table vectors, random stream, gapped valids, mid-flight reset,
// with a product scoreboard and a 5-cycle valid-timing model.

module tb_int_mult_pipe;
  localparam int K    = 54;
  localparam int LIMB = 18;
  localparam int W    = 24;
  localparam int RW   = 2*K;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [K-1:0]  mult_a = '0;
  logic [K-1:0]  mult_b = '0;
  logic          out_valid;
  logic [RW-1:0] int_mult_result;
  logic [W-1:0]  int_mult_result_low;
`ifdef INT_MULT_PERF_CNT_EN
  logic          clr_count = 1'b0;
  logic [31:0]   op_count;
`endif

  always #5 clk = ~clk;

  int_mult_pipe #(.K(K), .LIMB(LIMB), .W(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .mult_a              (mult_a),
    .mult_b              (mult_b),
    .out_valid           (out_valid),
    .int_mult_result     (int_mult_result),
    .int_mult_result_low (int_mult_result_low)
`ifdef INT_MULT_PERF_CNT_EN
    ,
    .clr_count           (clr_count),
    .op_count            (op_count)
`endif
  );

  typedef struct {
    logic [K-1:0]  a;
    logic [K-1:0]  b;
    logic [RW-1:0] res;
  } vec_t;

  logic [RW-1:0] sbq[$];
  logic [4:0]    hist = '0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [K-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[K-1:0];
  endfunction

  // One clock: drive at negedge, then check outputs just after the rising edge.
  task automatic cycle(input logic v, input logic [K-1:0] a, input logic [K-1:0] b,
                       input logic [RW-1:0] e);
    logic [RW-1:0] x;
    @(negedge clk);
    in_valid = v;
    mult_a   = a;
    mult_b   = b;
    if (v) sbq.push_back(e);
    @(posedge clk);
    hist = {hist[3:0], v};
    #1;
    chk("out_valid", RW'(out_valid), RW'(hist[4]));
    if (out_valid) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: out_valid=1 with no pending op");
      end else begin
        x = sbq.pop_front();
        chk("result", int_mult_result, x);
        chk("result_low", RW'(int_mult_result_low), RW'(x[W-1:0]));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd(), rnd(), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", RW'(out_valid), RW'(0));
    chk("rst_result", int_mult_result, RW'(0));
    chk("rst_result_low", RW'(int_mult_result_low), RW'(0));
    sbq.delete();
    hist = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t         tbl[6];
    int           pat[7];
    logic [K-1:0] ones;
    logic [K-1:0] ra, rb;

    ones   = '1;
    tbl[0] = '{ones, ones, RW'(0) - (RW'(1) << 55) + RW'(1)};
    tbl[1] = '{K'(0), K'(12345), RW'(0)};
    tbl[2] = '{K'(1), ones, (RW'(1) << K) - RW'(1)};
    tbl[3] = '{K'(1) << 18, (K'(1) << 36) - K'(1), (RW'(1) << 54) - (RW'(1) << 18)};
    tbl[4] = '{K'(3), K'(5), RW'(15)};
    tbl[5] = '{(K'(1) << LIMB) - K'(1), (K'(1) << LIMB) - K'(1),
               (RW'(1) << 36) - (RW'(1) << 19) + RW'(1)};
    pat    = '{1, 0, 0, 1, 1, 0, 1};

    #1;
    chk("init_out_valid", RW'(out_valid), RW'(0));
    chk("init_result", int_mult_result, RW'(0));
    chk("init_result_low", RW'(int_mult_result_low), RW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single all-ones pulse, valid must appear only 5 cycles later
    cycle(1'b1, ones, ones, tbl[0].res);
    idle(7);

    // table vectors followed immediately by a random back-to-back stream
    foreach (tbl[i]) cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].res);
    for (int i = 0; i < 20; i++) begin
      ra = rnd();
      rb = rnd();
      cycle(1'b1, ra, rb, RW'(ra) * RW'(rb));
    end
    idle(7);

    // gapped valid pattern
    for (int i = 0; i < 7; i++) begin
      ra = rnd();
      rb = rnd();
      cycle(pat[i] != 0, ra, rb, RW'(ra) * RW'(rb));
    end
    idle(7);

    // reset with three ops in flight, then a fresh op
    for (int i = 0; i < 3; i++) begin
      ra = rnd();
      rb = rnd();
      cycle(1'b1, ra, rb, RW'(ra) * RW'(rb));
    end
    do_reset();
    cycle(1'b1, tbl[3].a, tbl[3].b, tbl[3].res);
    idle(7);

`ifdef INT_MULT_PERF_CNT_EN
    do_reset();
    chk("op_count_rst", RW'(op_count), RW'(0));
    for (int i = 0; i < 7; i++) begin
      ra = rnd();
      rb = rnd();
      cycle(1'b1, ra, rb, RW'(ra) * RW'(rb));
    end
    idle(7);
    chk("op_count_7", RW'(op_count), RW'(7));
    cycle(1'b1, tbl[4].a, tbl[4].b, tbl[4].res);
    idle(4);
    clr_count = 1'b1;
    idle(1);
    chk("op_count_clr", RW'(op_count), RW'(0));
    clr_count = 1'b0;
    idle(3);
    chk("op_count_hold", RW'(op_count), RW'(0));
`endif

    chk("sb_drained", RW'(sbq.size()), RW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
